// File: rtl/gen_scheduler.sv
// Frame/generation scheduler: sequences one renderer and NUM_ENGINES parallel
// life-logic engines over a double buffer, with run/pause/single-step control,
// frames-per-generation pacing, a wrapping generation counter and a watchdog
// that abandons a generation whose done pulses never all arrive.
module gen_scheduler #(
  parameter int NUM_ENGINES    = 4,
  parameter int SPEED_W        = 4,
  parameter int GEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   pause_in,
  input  logic                   step_in,
  input  logic [SPEED_W-1:0]     speed_in,
  input  logic [NUM_ENGINES-1:0] engine_done_in,
  input  logic                   render_done_in,
  output logic [NUM_ENGINES-1:0] engine_start_out,
  output logic                   render_start_out,
  output logic                   buf_swap_out,
  output logic [GEN_W-1:0]       generation_out,
  output logic                   busy_out,
  output logic                   timeout_out
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_SWAP   = 2'd3
  } state_t;

  // A speed of zero frames per generation is treated as one.
  function automatic logic [SPEED_W-1:0] eff_speed(input logic [SPEED_W-1:0] s);
    if (s == {SPEED_W{1'b0}}) begin
      eff_speed = SPEED_W'(1);
    end else begin
      eff_speed = s;
    end
  endfunction

  state_t                 state_r;
  logic                   idle_wait_r;
  logic [SPEED_W-1:0]     frame_cnt_r;
  logic                   step_pending_r;
  logic                   logic_active_r;
  logic [NUM_ENGINES-1:0] eng_flag_r;
  logic                   render_flag_r;
  logic [WD_W-1:0]        wd_cnt_r;

  logic                   frame_last_s;
  logic                   gen_due_s;
  logic [NUM_ENGINES-1:0] eng_seen_s;
  logic                   render_seen_s;
  logic                   wait_exit_s;
  logic                   wd_expire_s;
  logic                   enter_launch_s;

  // Frame pacing, generation-due decision and S_WAIT exit/abort conditions.
  always_comb begin
    frame_last_s  = (frame_cnt_r >= (eff_speed(speed_in) - SPEED_W'(1)));
    if (pause_in) begin
      gen_due_s = step_pending_r;
    end else begin
      gen_due_s = frame_last_s;
    end
    eng_seen_s    = eng_flag_r | engine_done_in;
    render_seen_s = render_flag_r | render_done_in;
    wait_exit_s   = render_seen_s && (!logic_active_r || (&eng_seen_s));
    wd_expire_s   = (wd_cnt_r == WD_LAST);
  end

  // Which edges start a new frame (normal exit wins over watchdog expiry).
  always_comb begin
    enter_launch_s = 1'b0;
    case (state_r)
      S_IDLE:   enter_launch_s = idle_wait_r;
      S_LAUNCH: enter_launch_s = 1'b0;
      S_WAIT:   enter_launch_s = !wait_exit_s && wd_expire_s;
      S_SWAP:   enter_launch_s = 1'b1;
      default:  enter_launch_s = 1'b0;
    endcase
  end

  // Scheduler FSM with registered pulse outputs, step latch and counters.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r          <= S_IDLE;
      idle_wait_r      <= 1'b0;
      frame_cnt_r      <= '0;
      step_pending_r   <= 1'b0;
      logic_active_r   <= 1'b0;
      eng_flag_r       <= '0;
      render_flag_r    <= 1'b0;
      wd_cnt_r         <= '0;
      engine_start_out <= '0;
      render_start_out <= 1'b0;
      buf_swap_out     <= 1'b0;
      generation_out   <= '0;
      busy_out         <= 1'b0;
      timeout_out      <= 1'b0;
    end else begin
      engine_start_out <= '0;
      render_start_out <= 1'b0;
      buf_swap_out     <= 1'b0;

      // A new step request is kept even if the previous one is consumed now.
      if (!pause_in) begin
        step_pending_r <= 1'b0;
      end else if (step_in) begin
        step_pending_r <= 1'b1;
      end else if (enter_launch_s) begin
        step_pending_r <= 1'b0;
      end else begin
        step_pending_r <= step_pending_r;
      end

      case (state_r)
        S_IDLE: begin
          if (idle_wait_r) begin
            state_r <= S_LAUNCH;
          end else begin
            idle_wait_r <= 1'b1;
          end
        end
        S_LAUNCH: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_exit_s) begin
            state_r <= S_SWAP;
            if (logic_active_r) begin
              buf_swap_out   <= 1'b1;
              generation_out <= generation_out + GEN_W'(1);
              busy_out       <= 1'b0;
            end
          end else if (wd_expire_s) begin
            state_r     <= S_LAUNCH;
            timeout_out <= 1'b1;
            busy_out    <= 1'b0;
          end else begin
            eng_flag_r    <= eng_flag_r | (engine_done_in & {NUM_ENGINES{logic_active_r}});
            render_flag_r <= render_seen_s;
            wd_cnt_r      <= wd_cnt_r + WD_W'(1);
          end
        end
        S_SWAP: begin
          state_r <= S_LAUNCH;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase

      // Frame launch: start renderer always, engines only when a generation is due.
      if (enter_launch_s) begin
        render_start_out <= 1'b1;
        eng_flag_r       <= '0;
        render_flag_r    <= 1'b0;
        wd_cnt_r         <= '0;
        if (gen_due_s) begin
          engine_start_out <= '1;
          logic_active_r   <= 1'b1;
          busy_out         <= 1'b1;
        end else begin
          logic_active_r   <= 1'b0;
        end
        if (!pause_in) begin
          frame_cnt_r <= frame_last_s ? '0 : (frame_cnt_r + SPEED_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_gen_scheduler.sv
// Randomized scoreboard bench for gen_scheduler. The driver plays the engines
// and renderer, changes pause/step/speed mid-frame and pushes expected frame
// launches and frame outcomes; a negedge monitor pops and compares them.
module tb_gen_scheduler;

  localparam int NE    = 4;
  localparam int SW    = 4;
  localparam int GW    = 4;
  localparam int TO    = 64;
  localparam int NEVER = 1000;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          pause_in;
  logic          step_in;
  logic [SW-1:0] speed_in;
  logic [NE-1:0] engine_done_in;
  logic          render_done_in;
  logic [NE-1:0] engine_start_out;
  logic          render_start_out;
  logic          buf_swap_out;
  logic [GW-1:0] generation_out;
  logic          busy_out;
  logic          timeout_out;

  gen_scheduler #(.NUM_ENGINES(NE), .SPEED_W(SW), .GEN_W(GW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .pause_in(pause_in), .step_in(step_in),
    .speed_in(speed_in), .engine_done_in(engine_done_in), .render_done_in(render_done_in),
    .engine_start_out(engine_start_out), .render_start_out(render_start_out),
    .buf_swap_out(buf_swap_out), .generation_out(generation_out), .busy_out(busy_out),
    .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit swap;
    int swap_cyc;
    int start_cyc;
    int gen;
    bit to;
  } outcome_t;

  bit       launch_q[$];
  outcome_t out_q[$];

  // Reference model state: frames counted per generation, pending step, results.
  bit m_pause;
  int m_speed;
  int m_fc;
  bit m_sp;
  int m_gen;
  bit m_to;
  int n_to;
  bit cur_due;

  task automatic model_reset();
    m_fc = 0; m_sp = 0; m_gen = 0; m_to = 0;
  endtask

  // A generation is due on every eff-th running frame, or on a pending step when paused.
  task automatic model_launch(output bit due);
    int eff;
    eff = (m_speed == 0) ? 1 : m_speed;
    if (!m_pause) begin
      m_fc = m_fc + 1;
      due  = (m_fc == eff);
      if (due) m_fc = 0;
    end else begin
      due  = m_sp;
      m_sp = 0;
    end
  endtask

  // Monitor: compare launches and the outcome of the previous frame.
  bit       mon_en = 0;
  bit       have_prev = 0;
  int       swaps_seen = 0;
  int       swap_seen_cyc = -1;
  outcome_t mon_o;
  bit       mon_due;

  always @(negedge clk_in) begin
    if (mon_en) begin
      if (buf_swap_out) begin
        swaps_seen++;
        swap_seen_cyc = cyc;
        check("busy_at_swap", 64'(busy_out), 64'(0));
      end
      if (render_start_out) begin
        if (have_prev) begin
          if (out_q.size() == 0) begin
            check("outcome_available", 64'(0), 64'(1));
          end else begin
            mon_o = out_q.pop_front();
            check("next_start_cycle", 64'(cyc), 64'(mon_o.start_cyc));
            check("swap_count", 64'(swaps_seen), 64'(mon_o.swap));
            if (mon_o.swap) check("swap_cycle", 64'(swap_seen_cyc), 64'(mon_o.swap_cyc));
            check("generation", 64'(generation_out), 64'(mon_o.gen));
            check("timeout", 64'(timeout_out), 64'(mon_o.to));
          end
        end
        if (launch_q.size() == 0) begin
          check("launch_available", 64'(0), 64'(1));
        end else begin
          mon_due = launch_q.pop_front();
          check("engine_start", 64'(engine_start_out), 64'({NE{mon_due}}));
          check("busy_at_launch", 64'(busy_out), 64'(mon_due));
        end
        have_prev  = 1;
        swaps_seen = 0;
      end else begin
        check("stray_engine_start", 64'(engine_start_out), 64'(0));
      end
    end
  end

  task automatic wait_launch(output int lc);
    int budget;
    budget = 0;
    while (!render_start_out && budget < 200) begin
      @(posedge clk_in); #1;
      budget++;
    end
    if (!render_start_out) check("launch_wait_expired", 64'(0), 64'(1));
    lc = cyc;
  endtask

  task automatic run_frame(input int k);
    int       lc, t_ren, dmax;
    int       t_eng[NE];
    bit       to, due, nd, spur;
    outcome_t o;
    wait_launch(lc);
    due  = cur_due;
    to   = 0;
    spur = (k >= 1) && ($urandom_range(0, 3) == 0);
    if (k == 0) begin
      t_eng = '{20, 27, 30, 35};
      t_ren = 50;
    end else begin
      for (int i = 0; i < NE; i++) t_eng[i] = $urandom_range(4, 30);
      t_ren = $urandom_range(4, 30);
      if (k == 2 || $urandom_range(0, 11) == 0) t_ren = TO;
      if (k == 1 || ($urandom_range(0, 9) == 0 && n_to < 5)) begin
        to = 1;
        n_to++;
        if (due) t_eng[2] = NEVER;
        else t_ren = NEVER;
      end
    end
    if (to) begin
      dmax = TO;
    end else begin
      dmax = t_ren;
      if (due) for (int i = 0; i < NE; i++) if (t_eng[i] > dmax) dmax = t_eng[i];
    end
    for (int d = 0; d <= dmax; d++) begin
      if (d > 0) begin
        @(posedge clk_in); #1;
      end
      for (int i = 0; i < NE; i++) engine_done_in[i] = (t_eng[i] == d);
      render_done_in = (t_ren == d);
      step_in = 1'b0;
      if (d == 0 && spur) begin
        engine_done_in = '1;
        render_done_in = 1'b1;
      end
      if (k >= 2 && d == 1) begin
        if ($urandom_range(0, 3) == 0) begin
          m_pause  = !m_pause;
          pause_in = m_pause;
          if (!m_pause) m_sp = 0;
        end
        if (m_fc == 0 && $urandom_range(0, 3) == 0) begin
          m_speed  = $urandom_range(0, 4);
          speed_in = SW'(m_speed);
        end
      end
      if (k >= 2 && (d == 2 || d == 3) && $urandom_range(0, 1) == 1) begin
        step_in = 1'b1;
        if (m_pause) m_sp = 1;
      end
      if (d == dmax) begin
        if (to) m_to = 1;
        else if (due) m_gen = (m_gen + 1) % (1 << GW);
        o.swap      = due && !to;
        o.swap_cyc  = lc + dmax + 1;
        o.start_cyc = to ? (lc + TO + 1) : (lc + dmax + 2);
        o.gen       = m_gen;
        o.to        = m_to;
        out_q.push_back(o);
        model_launch(nd);
        launch_q.push_back(nd);
        cur_due = nd;
      end
    end
    @(posedge clk_in); #1;
    engine_done_in = '0;
    render_done_in = 1'b0;
    step_in        = 1'b0;
  endtask

  initial begin
    int  lc;
    bit  nd;
    rst_n_in       = 1'b0;
    pause_in       = 1'b0;
    step_in        = 1'b0;
    speed_in       = SW'(1);
    engine_done_in = '0;
    render_done_in = 1'b0;
    m_pause = 0; m_speed = 1; n_to = 0;
    model_reset();
    #12;
    check("reset_engine_start", 64'(engine_start_out), 64'(0));
    check("reset_render_start", 64'(render_start_out), 64'(0));
    check("reset_buf_swap", 64'(buf_swap_out), 64'(0));
    check("reset_generation", 64'(generation_out), 64'(0));
    check("reset_busy", 64'(busy_out), 64'(0));
    check("reset_timeout", 64'(timeout_out), 64'(0));
    model_launch(nd);
    launch_q.push_back(nd);
    cur_due = nd;
    mon_en  = 1;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    for (int k = 0; k < 140; k++) run_frame(k);

    // Reset in the middle of a frame's wait phase.
    wait_launch(lc);
    repeat (5) begin
      @(posedge clk_in); #1;
    end
    mon_en   = 0;
    rst_n_in = 1'b0;
    #1;
    check("midrst_engine_start", 64'(engine_start_out), 64'(0));
    check("midrst_render_start", 64'(render_start_out), 64'(0));
    check("midrst_buf_swap", 64'(buf_swap_out), 64'(0));
    check("midrst_generation", 64'(generation_out), 64'(0));
    check("midrst_busy", 64'(busy_out), 64'(0));
    check("midrst_timeout", 64'(timeout_out), 64'(0));
    launch_q.delete();
    out_q.delete();
    have_prev  = 0;
    swaps_seen = 0;
    model_reset();
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    model_launch(nd);
    launch_q.push_back(nd);
    cur_due = nd;
    mon_en  = 1;
    @(posedge clk_in); #1;
    check("post_reset_start_early", 64'(render_start_out), 64'(0));
    @(posedge clk_in); #1;
    check("post_reset_start_2cyc", 64'(render_start_out), 64'(1));
    for (int k = 200; k < 260; k++) run_frame(k);

    wait_launch(lc);
    repeat (3) @(posedge clk_in);
    #1;
    check("launch_q_drained", 64'(launch_q.size()), 64'(0));
    check("outcome_q_drained", 64'(out_q.size()), 64'(0));
    check("final_generation", 64'(generation_out), 64'(m_gen));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
